// File: rtl/skip_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : skip_gen_if
// Description : Control/status bundle for the multi-channel clock skipper.
// Revision    : 1.0 - initial release
// ============================================================================
interface skip_gen_if #(
    parameter int LEN  = 16,
    parameter int CH   = 2,
    parameter int DIVW = 24
);
    logic                  E;
    logic                  CLR;
    logic [DIVW-1:0]       DIV;
    logic [CH-1:0]         LD;
    logic [CH*LEN-1:0]     LD_MASK;
    logic [CH*LEN-1:0]     LD_SEL;
    logic [CH-1:0]         LD_BUSY;
    logic [CH-1:0]         LD_ACK;
    logic                  oTICK;
    logic [CH-1:0]         oEN;
    logic [CH-1:0]         oB0;

    modport master (
        output E, CLR, DIV, LD, LD_MASK, LD_SEL,
        input  LD_BUSY, LD_ACK, oTICK, oEN, oB0
    );

    modport slave (
        input  E, CLR, DIV, LD, LD_MASK, LD_SEL,
        output LD_BUSY, LD_ACK, oTICK, oEN, oB0
    );
endinterface
`default_nettype wire

// File: rtl/skip_gen.sv
`default_nettype none
// ============================================================================
// Module      : skip_gen
// Description : Shared prescaler driving CH one-hot phase rings; each ring
//               emits a clock-enable pulse per tick unless masked.
// Revision    : 1.0 - initial release
// ============================================================================
module skip_gen #(
    parameter int             LEN     = 16,
    parameter int             CH      = 2,
    parameter int             DIVW    = 24,
    parameter logic [LEN-1:0] defSEL  = {{(LEN-1){1'b0}}, 1'b1},
    parameter logic [LEN-1:0] defMASK = '0
) (
    input  wire         iCLK,
    input  wire         nRST,
    skip_gen_if.slave   bus
);

    function automatic logic is_onehot(input logic [LEN-1:0] v);
        return (v != '0) && ((v & (v - LEN'(1))) == '0);
    endfunction

    logic [DIVW-1:0]          cnt_q,    cnt_d;
    logic                     tick_q,   tick_d;
    logic [CH-1:0]            en_q,     en_d;
    logic [CH-1:0]            ack_q,    ack_d;
    logic [CH-1:0]            pend_q,   pend_d;
    logic [CH-1:0][LEN-1:0]   ring_q,   ring_d;
    logic [CH-1:0][LEN-1:0]   mask_q,   mask_d;
    logic [CH-1:0][LEN-1:0]   shmask_q, shmask_d;
    logic [CH-1:0][LEN-1:0]   shsel_q,  shsel_d;
    logic                     w_tick;
    logic [CH-1:0]            w_b0;

    // CLR suppresses the tick so that it wins over wrap-time reloads.
    always_comb begin
        w_tick = bus.E && !bus.CLR && (cnt_q >= bus.DIV);
    end

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = w_tick;
        if (bus.CLR) begin
            cnt_d = '0;
        end else if (w_tick) begin
            cnt_d = '0;
        end else if (bus.E) begin
            cnt_d = cnt_q + DIVW'(1);
        end
    end

    always_comb begin
        ring_d   = ring_q;
        mask_d   = mask_q;
        shmask_d = shmask_q;
        shsel_d  = shsel_q;
        pend_d   = pend_q;
        en_d     = '0;
        ack_d    = '0;
        for (int c = 0; c < CH; c++) begin
            if (bus.CLR) begin
                ring_d[c] = defSEL;
                pend_d[c] = 1'b0;
            end else begin
                if (w_tick) begin
                    en_d[c] = ~|(ring_q[c] & mask_q[c]);
                    if (ring_q[c][LEN-1] && pend_q[c]) begin
                        ring_d[c] = is_onehot(shsel_q[c]) ? shsel_q[c] : defSEL;
                        mask_d[c] = shmask_q[c];
                        pend_d[c] = 1'b0;
                        ack_d[c]  = 1'b1;
                    end else begin
                        ring_d[c] = {ring_q[c][LEN-2:0], ring_q[c][LEN-1]};
                    end
                end
                // A request landing on the applying tick becomes the next pending load.
                if (bus.LD[c]) begin
                    shmask_d[c] = bus.LD_MASK[c*LEN +: LEN];
                    shsel_d[c]  = bus.LD_SEL[c*LEN +: LEN];
                    pend_d[c]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            en_q     <= '0;
            ack_q    <= '0;
            pend_q   <= '0;
            ring_q   <= {CH{defSEL}};
            mask_q   <= {CH{defMASK}};
            shmask_q <= {CH{defMASK}};
            shsel_q  <= {CH{defSEL}};
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            en_q     <= en_d;
            ack_q    <= ack_d;
            pend_q   <= pend_d;
            ring_q   <= ring_d;
            mask_q   <= mask_d;
            shmask_q <= shmask_d;
            shsel_q  <= shsel_d;
        end
    end

    always_comb begin
        w_b0 = '0;
        for (int c = 0; c < CH; c++) begin
            w_b0[c] = ring_q[c][0];
        end
    end

    assign bus.oTICK   = tick_q;
    assign bus.oEN     = en_q;
    assign bus.LD_ACK  = ack_q;
    assign bus.LD_BUSY = pend_q;
    assign bus.oB0     = w_b0;

endmodule
`default_nettype wire

// File: tb/tb_skip_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_skip_gen
// Description : Directed self-checking bench for skip_gen (LEN=16, CH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skip_gen;

    logic iCLK = 1'b0;
    logic nRST = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] exp_en, exp_ack, exp_busy, exp_b0;
    logic       exp_t;

    skip_gen_if #(.LEN(16), .CH(2), .DIVW(24)) bus ();

    skip_gen #(.LEN(16), .CH(2), .DIVW(24)) dut (
        .iCLK (iCLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset();
        bus.E = 1'b0; bus.CLR = 1'b0; bus.DIV = '0; bus.LD = '0;
        bus.LD_MASK = '0; bus.LD_SEL = '0;
        nRST = 1'b0;
        step(); step();
        checks++; if (bus.oTICK !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.oTICK); end
        checks++; if (bus.oEN !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", bus.oEN); end
        checks++; if (bus.LD_BUSY !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", bus.LD_BUSY); end
        checks++; if (bus.LD_ACK !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", bus.LD_ACK); end
        checks++; if (bus.oB0 !== 2'b11) begin failures++; $display("FAIL reset_b0 got=%b exp=11", bus.oB0); end
    endtask

    task automatic test_prescaler();
        int ticks;
        ticks = 0;
        bus.DIV = 24'd3; bus.E = 1'b1;
        nRST = 1'b1;
        for (int k = 1; k <= 68; k++) begin
            step();
            exp_t = ((k % 4) == 0);
            if (exp_t) ticks++;
            exp_en = exp_t ? 2'b11 : 2'b00;
            exp_b0 = ((ticks % 16) == 0) ? 2'b11 : 2'b00;
            checks++;
            if ({bus.oTICK, bus.oEN, bus.oB0} !== {exp_t, exp_en, exp_b0}) begin
                failures++;
                $display("FAIL prescale k=%0d got tick/en/b0=%b exp=%b", k,
                         {bus.oTICK, bus.oEN, bus.oB0}, {exp_t, exp_en, exp_b0});
            end
        end
    endtask

    task automatic test_pattern();
        int pulses;
        pulses = 0;
        bus.E = 1'b0; bus.CLR = 1'b1; bus.DIV = '0;
        step();
        bus.CLR = 1'b0; bus.LD = 2'b01;
        bus.LD_MASK = {16'h0000, 16'hCCCC}; bus.LD_SEL = {16'h0001, 16'h0001};
        step();
        bus.LD = 2'b00;
        checks++;
        if ({bus.LD_BUSY, bus.LD_ACK} !== 4'b0100) begin
            failures++; $display("FAIL pattern_ld got busy/ack=%b exp=0100", {bus.LD_BUSY, bus.LD_ACK});
        end
        bus.E = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            exp_en   = {1'b1, (i < 16) ? 1'b1 : (((i - 16) % 4) < 2)};
            exp_ack  = (i == 15) ? 2'b01 : 2'b00;
            exp_busy = (i < 15) ? 2'b01 : 2'b00;
            exp_b0   = (((i + 1) % 16) == 0) ? 2'b11 : 2'b00;
            checks++;
            if ({bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY, bus.oB0} !== {1'b1, exp_en, exp_ack, exp_busy, exp_b0}) begin
                failures++;
                $display("FAIL pattern i=%0d got=%b exp=%b", i,
                         {bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY, bus.oB0},
                         {1'b1, exp_en, exp_ack, exp_busy, exp_b0});
            end
            if (i >= 16 && bus.oEN[0]) pulses++;
        end
        checks++; if (pulses != 8) begin failures++; $display("FAIL pattern_count got=%0d exp=8", pulses); end
    endtask

    task automatic test_midload();
        bus.LD_MASK = {16'h0000, 16'hFF00}; bus.LD_SEL = {16'h0001, 16'h0001};
        for (int p = 0; p < 16; p++) begin
            bus.LD = (p == 5) ? 2'b01 : 2'b00;
            step();
            exp_en   = {1'b1, ((p % 4) < 2)};
            exp_busy = (p >= 5 && p <= 14) ? 2'b01 : 2'b00;
            exp_ack  = (p == 15) ? 2'b01 : 2'b00;
            checks++;
            if ({bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== {exp_en, exp_ack, exp_busy}) begin
                failures++;
                $display("FAIL midload p=%0d got en/ack/busy=%b exp=%b", p,
                         {bus.oEN, bus.LD_ACK, bus.LD_BUSY}, {exp_en, exp_ack, exp_busy});
            end
        end
        bus.LD = 2'b00;
        for (int p = 0; p < 16; p++) begin
            step();
            exp_en = {1'b1, (p < 8)};
            checks++;
            if ({bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== {exp_en, 4'b0000}) begin
                failures++;
                $display("FAIL newpat p=%0d got en/ack/busy=%b exp=%b", p,
                         {bus.oEN, bus.LD_ACK, bus.LD_BUSY}, {exp_en, 4'b0000});
            end
        end
    endtask

    task automatic test_bad_sel();
        int acks;
        acks = 0;
        bus.LD_MASK = {16'h0002, 16'h0000}; bus.LD_SEL = {16'h0003, 16'h0000};
        for (int p = 0; p < 16; p++) begin
            bus.LD = (p == 3) ? 2'b10 : 2'b00;
            step();
            exp_en   = {1'b1, (p < 8)};
            exp_busy = {(p >= 3 && p <= 14), 1'b0};
            exp_ack  = {(p == 15), 1'b0};
            checks++;
            if ({bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== {exp_en, exp_ack, exp_busy}) begin
                failures++;
                $display("FAIL badsel_ld p=%0d got=%b exp=%b", p,
                         {bus.oEN, bus.LD_ACK, bus.LD_BUSY}, {exp_en, exp_ack, exp_busy});
            end
        end
        for (int p = 0; p < 16; p++) begin
            bus.LD = (p == 2 || p == 9) ? 2'b10 : 2'b00;
            if (p == 2) begin bus.LD_MASK = {16'hFFFF, 16'h0000}; bus.LD_SEL = {16'h0010, 16'h0000}; end
            if (p == 9) begin bus.LD_MASK = {16'h8000, 16'h0000}; bus.LD_SEL = {16'h0004, 16'h0000}; end
            step();
            exp_en   = {(p != 1), (p < 8)};
            exp_busy = {(p >= 2 && p <= 14), 1'b0};
            exp_ack  = {(p == 15), 1'b0};
            if (bus.LD_ACK[1]) acks++;
            checks++;
            if ({bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== {exp_en, exp_ack, exp_busy}) begin
                failures++;
                $display("FAIL defsel_relo p=%0d got=%b exp=%b", p,
                         {bus.oEN, bus.LD_ACK, bus.LD_BUSY}, {exp_en, exp_ack, exp_busy});
            end
        end
        bus.LD = 2'b00;
        checks++; if (acks != 1) begin failures++; $display("FAIL double_ld_acks got=%0d exp=1", acks); end
        for (int q = 0; q < 16; q++) begin
            step();
            exp_en = {(q != 13), (q < 8)};
            checks++;
            if ({bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== {exp_en, 4'b0000}) begin
                failures++;
                $display("FAIL lastwins q=%0d got=%b exp=%b", q,
                         {bus.oEN, bus.LD_ACK, bus.LD_BUSY}, {exp_en, 4'b0000});
            end
        end
    endtask

    task automatic test_div_change();
        bus.DIV = 24'd100; bus.E = 1'b1; bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        checks++; if ({bus.oTICK, bus.oEN} !== 3'b000) begin failures++; $display("FAIL clr_out got=%b exp=000", {bus.oTICK, bus.oEN}); end
        for (int k = 1; k <= 50; k++) begin
            step();
            checks++; if (bus.oTICK !== 1'b0) begin failures++; $display("FAIL div100 k=%0d got=%b exp=0", k, bus.oTICK); end
        end
        bus.DIV = 24'd2;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_t = (k == 1 || k == 4 || k == 7);
            checks++; if (bus.oTICK !== exp_t) begin failures++; $display("FAIL div2 k=%0d got=%b exp=%b", k, bus.oTICK, exp_t); end
        end
        bus.E = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if ({bus.oTICK, bus.oEN} !== 3'b000) begin failures++; $display("FAIL e_low k=%0d got=%b exp=000", k, {bus.oTICK, bus.oEN}); end
        end
        bus.E = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_t = (k == 2 || k == 5);
            checks++; if (bus.oTICK !== exp_t) begin failures++; $display("FAIL e_resume k=%0d got=%b exp=%b", k, bus.oTICK, exp_t); end
        end
    endtask

    task automatic test_async_reset();
        bus.DIV = '0; bus.E = 1'b1;
        step(); step();
        bus.LD = 2'b01; bus.LD_MASK = {16'h0000, 16'hFFFF}; bus.LD_SEL = {16'h0001, 16'h0001};
        step();
        bus.LD = 2'b00;
        checks++; if (bus.LD_BUSY !== 2'b01) begin failures++; $display("FAIL ar_pending got=%b exp=01", bus.LD_BUSY); end
        #3 nRST = 1'b0;
        #1;
        checks++;
        if ({bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY, bus.oB0} !== 9'b0_00_00_00_11) begin
            failures++;
            $display("FAIL async_rst got=%b exp=000000011", {bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY, bus.oB0});
        end
        step();
        nRST = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== 7'b1_11_00_00) begin
                failures++;
                $display("FAIL ar_after k=%0d got=%b exp=1110000", k, {bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY});
            end
        end
    endtask

    task automatic test_clr_priority();
        nRST = 1'b0; bus.E = 1'b1; bus.DIV = '0; bus.LD = 2'b00;
        bus.LD_MASK = {16'h0000, 16'hFFFF}; bus.LD_SEL = {16'h0001, 16'h0001};
        step();
        nRST = 1'b1;
        for (int p = 0; p < 16; p++) begin
            bus.LD  = (p == 3 || p == 15) ? 2'b01 : 2'b00;
            bus.CLR = (p == 15);
            step();
            if (p < 15) begin
                exp_busy = (p >= 3) ? 2'b01 : 2'b00;
                checks++;
                if ({bus.LD_ACK, bus.LD_BUSY} !== {2'b00, exp_busy}) begin
                    failures++; $display("FAIL clr_pre p=%0d got=%b exp=%b", p, {bus.LD_ACK, bus.LD_BUSY}, {2'b00, exp_busy});
                end
            end else begin
                checks++;
                if ({bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY, bus.oB0} !== 9'b0_00_00_00_11) begin
                    failures++;
                    $display("FAIL clr_prio got=%b exp=000000011", {bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY, bus.oB0});
                end
            end
        end
        bus.CLR = 1'b0; bus.LD = 2'b00;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if ({bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY} !== 7'b1_11_00_00) begin
                failures++;
                $display("FAIL clr_after k=%0d got=%b exp=1110000", k, {bus.oTICK, bus.oEN, bus.LD_ACK, bus.LD_BUSY});
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_pattern();
        test_midload();
        test_bad_sel();
        test_div_change();
        test_async_reset();
        test_clr_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
